// File: rtl/tx_sched.sv
// tx_sched: round-robin frame scheduler feeding the RGMII transmitter.
// Grants one source per frame, tracks txctl and enforces the inter-frame gap.
`timescale 1ns/1ps
module tx_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned SELW   = 2,
    parameter int unsigned IFG    = 12,
    parameter int unsigned TMO    = 16,
    parameter int unsigned MAXLEN = 1100
) (
    input  logic            clk125,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            txctl,
    output logic            idx,
    output logic [SELW-1:0] sel,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            err,
    output logic            busy,
    output logic [15:0]     frames
);

    typedef enum logic [2:0] {
        DRAIN,
        GAP,
        IDLE,
        KICK,
        SEND
    } state_t;

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t          state_q, state_d;
    logic [10:0]     cnt_q, cnt_d, cnt_inc;
    logic [SELW-1:0] ptr_q, ptr_d, pick;
    logic            idx_q, idx_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [15:0]     frames_q, frames_d;

    // Descending scan so the nearest index after p wins.
    function automatic logic [SELW-1:0] rr_pick(
        input logic [SELW-1:0] p,
        input logic [NREQ-1:0] r
    );
        logic [SELW-1:0] res;
        int              j;
        res = p;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(p) + k) % NREQ;
            if (r[SELW'(j)]) res = SELW'(j);
        end
        return res;
    endfunction

    assign pick    = rr_pick(ptr_q, req);
    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        frames_d = frames_q;
        unique case (state_q)
            DRAIN: begin
                if (!txctl) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (txctl) begin
                    cnt_d = '0;
                end else if (cnt_q == 11'(IFG - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (|req) begin
                    state_d = KICK;
                    cnt_d   = '0;
                    ptr_d   = pick;
                    sel_d   = pick;
                    gnt_d   = ONE << pick;
                    idx_d   = ~idx_q;
                end
            end
            KICK: begin
                if (txctl) begin
                    state_d = SEND;
                    cnt_d   = '0;
                end else if (cnt_q == 11'(TMO - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    done_d  = ONE << sel_q;
                    gnt_d   = '0;
                end
            end
            SEND: begin
                if (!txctl) begin
                    state_d  = GAP;
                    cnt_d    = '0;
                    done_d   = ONE << sel_q;
                    frames_d = frames_q + 16'd1;
                    gnt_d    = '0;
                end else if (cnt_q == 11'(MAXLEN - 1)) begin
                    // Transmitter still running: wait for the wire to go idle.
                    state_d = DRAIN;
                    err_d   = 1'b1;
                    done_d  = ONE << sel_q;
                    gnt_d   = '0;
                end
            end
            default: state_d = DRAIN;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state_q  <= DRAIN;
            cnt_q    <= '0;
            ptr_q    <= SELW'(NREQ - 1);
            idx_q    <= 1'b0;
            sel_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            frames_q <= frames_d;
        end
    end

    assign idx    = idx_q;
    assign sel    = sel_q;
    assign gnt    = gnt_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign frames = frames_q;

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: directed scoreboard bench for tx_sched with a simple
// transmitter model reacting to idx toggles.
`timescale 1ns/1ps
module tb_tx_sched;

    localparam int NREQ   = 4;
    localparam int SELW   = 2;
    localparam int IFG    = 12;
    localparam int TMO    = 16;
    localparam int MAXLEN = 1100;

    logic        clk125 = 1'b0;
    logic        rst    = 1'b1;
    logic [3:0]  req    = 4'b0000;
    logic        tx_m   = 1'b0;
    logic        tx_f   = 1'b0;
    logic        txctl;
    logic        idx;
    logic [1:0]  sel;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic [15:0] frames;

    assign txctl = tx_m | tx_f;

    tx_sched #(
        .NREQ(NREQ), .SELW(SELW), .IFG(IFG), .TMO(TMO), .MAXLEN(MAXLEN)
    ) dut (
        .clk125(clk125), .rst(rst), .req(req), .txctl(txctl),
        .idx(idx), .sel(sel), .gnt(gnt), .done(done), .err(err),
        .busy(busy), .frames(frames)
    );

    always #4 clk125 = ~clk125;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       idx;
        bit         exact;
    } gexp_t;

    typedef struct {
        logic [3:0]  done;
        int          kind;
        logic [15:0] frames;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ngrant = 0;
    int ndone = 0;
    int tog_cyc = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int force_fall = 0;
    int last_done = 0;
    int tx_delay = 6;
    int tx_len = 100;
    bit tx_never = 0;
    logic midx = 1'b0;
    logic pidx = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic pg(input logic [1:0] s, input logic [3:0] g,
                      input logic i, input bit ex);
        gexp_t e;
        e.sel = s; e.gnt = g; e.idx = i; e.exact = ex;
        gq.push_back(e);
    endtask

    task automatic pd(input logic [3:0] d, input int k,
                      input logic [15:0] f);
        dexp_t e;
        e.done = d; e.kind = k; e.frames = f;
        dq.push_back(e);
    endtask

    task automatic wait_grants(input int n, input int lim);
        int i = 0;
        while (ngrant < n && i < lim) begin
            @(negedge clk125);
            i++;
        end
        if (ngrant < n) begin
            checks++; errors++;
            $display("FAIL wait_grants got %0d want %0d", ngrant, n);
        end
    endtask

    task automatic wait_dones(input int n, input int lim);
        int i = 0;
        while (ndone < n && i < lim) begin
            @(negedge clk125);
            i++;
        end
        if (ndone < n) begin
            checks++; errors++;
            $display("FAIL wait_dones got %0d want %0d", ndone, n);
        end
    endtask

    initial forever begin
        @(posedge clk125);
        cyc++;
    end

    // Transmitter model: one frame per idx toggle.
    initial forever begin
        @(negedge clk125);
        if (rst) begin
            midx = idx;
        end else if (idx !== midx) begin
            midx = idx;
            if (!tx_never) begin
                repeat (tx_delay) @(posedge clk125);
                #1;
                tx_m = 1'b1;
                rise_cyc = cyc + 1;
                repeat (tx_len) @(posedge clk125);
                #1;
                tx_m = 1'b0;
                fall_cyc = cyc + 1;
            end
        end
    end

    // Monitor: pops expectations on grant toggles and done/err pulses.
    initial forever begin
        gexp_t g;
        dexp_t d;
        int    rf;
        @(negedge clk125);
        if (rst) begin
            pidx = idx;
        end else begin
            if (idx !== pidx) begin
                pidx = idx;
                tog_cyc = cyc;
                ngrant++;
                rf = force_fall;
                if (fall_cyc > rf) rf = fall_cyc;
                if (last_done > rf) rf = last_done;
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL grant_unexpected got sel %0d want none", sel);
                end else begin
                    g = gq.pop_front();
                    chk("grant_sel", sel, g.sel);
                    chk("grant_gnt", gnt, g.gnt);
                    chk("grant_idx", idx, g.idx);
                    if (g.exact) chk("grant_gap", cyc - rf, IFG + 1);
                    else chk("grant_gap_min", (cyc - rf) >= IFG + 1, 1);
                end
            end
            if (done !== 4'b0000 || err !== 1'b0) begin
                ndone++;
                last_done = cyc;
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected got done %b err %b want none",
                             done, err);
                end else begin
                    d = dq.pop_front();
                    chk("done_bits", done, d.done);
                    chk("done_err", err, d.kind != 0);
                    chk("done_frames", frames, d.frames);
                    chk("done_gnt_clr", gnt, 0);
                    chk("done_busy", busy, 1);
                    case (d.kind)
                        0: chk("done_lat", cyc, fall_cyc);
                        1: chk("tmo_lat", cyc - tog_cyc, TMO);
                        default: chk("ovr_lat", cyc - rise_cyc, MAXLEN);
                    endcase
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        // Reset mid-frame, then round robin over all four sources.
        rst  = 1'b1;
        tx_f = 1'b1;
        req  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            pg(2'(k % 4), 4'b0001 << (k % 4), (k % 2) == 0, 1);
            pd(4'b0001 << (k % 4), 0, 16'(k + 1));
        end
        repeat (3) @(negedge clk125);
        chk("rst_idx", idx, 0);
        chk("rst_sel", sel, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 1);
        chk("rst_frames", frames, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk125);
            if (idx !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) bad = 1;
        end
        chk("drain_hold", bad, 0);
        @(posedge clk125);
        #1;
        tx_f = 1'b0;
        force_fall = cyc + 1;
        wait_grants(8, 3000);
        req = 4'b0000;
        wait_dones(8, 3000);

        // Single source, long frame, back-to-back re-grant.
        tx_len = 1052;
        pg(2'd2, 4'b0100, 1'b1, 0);
        pd(4'b0100, 0, 16'd9);
        pg(2'd2, 4'b0100, 1'b0, 1);
        pd(4'b0100, 0, 16'd10);
        req = 4'b0100;
        wait_grants(10, 4000);
        req = 4'b0000;
        wait_dones(10, 4000);

        // Start timeout, then a good frame.
        tx_never = 1;
        pg(2'd0, 4'b0001, 1'b1, 0);
        pd(4'b0001, 1, 16'd10);
        pg(2'd0, 4'b0001, 1'b0, 1);
        pd(4'b0001, 0, 16'd11);
        req = 4'b0001;
        wait_dones(11, 500);
        tx_never = 0;
        tx_len = 50;
        wait_grants(12, 500);
        req = 4'b0000;
        wait_dones(12, 500);

        // Length overrun, drain, then a good frame.
        tx_len = 1200;
        pg(2'd3, 4'b1000, 1'b1, 0);
        pd(4'b1000, 2, 16'd11);
        pg(2'd3, 4'b1000, 1'b0, 1);
        pd(4'b1000, 0, 16'd12);
        req = 4'b1000;
        wait_dones(13, 2000);
        tx_len = 50;
        wait_grants(14, 500);
        req = 4'b0000;
        wait_dones(14, 500);

        // Source 1 drops its request mid-frame.
        pg(2'd1, 4'b0010, 1'b1, 0);
        pd(4'b0010, 0, 16'd13);
        pg(2'd2, 4'b0100, 1'b0, 1);
        pd(4'b0100, 0, 16'd14);
        req = 4'b0110;
        wait_grants(15, 500);
        for (int i = 0; i < 100 && tx_m !== 1'b1; i++) @(negedge clk125);
        repeat (10) @(negedge clk125);
        req = 4'b0100;
        wait_grants(16, 500);
        req = 4'b0000;
        wait_dones(16, 500);

        repeat (30) @(negedge clk125);
        chk("idle_busy", busy, 0);
        chk("final_frames", frames, 14);
        chk("gq_empty", gq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_sched.md
Name: tx_sched

Overview:
- Round-robin frame scheduler in front of the RGMII frame transmitter.
- Arbitrates NREQ payload sources, each holding a ready 1024-byte buffer. Holds the selected source's mux select stable for the whole frame and issues the transmit request by toggling `idx`.
- Tracks the frame through the transmitter's `txctl`, enforces the inter-frame gap, and reports completion or error per source.

Parameters:
- NREQ, 4, number of requesting sources (2..8).
- SELW, 2, width of `sel`; must equal clog2(NREQ).
- IFG, 12, idle cycles after `txctl` falls before the next grant (min 1).
- TMO, 16, max cycles from the `idx` toggle to `txctl` rising.
- MAXLEN, 1100, max cycles `txctl` may stay high per frame.

Ports:
- clk125  in  1  125 MHz clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  level; bit i high = source i buffer full and ready.
- txctl  in  1  transmitter enable, high while a frame is on the wire.
- idx  out  1  transmit request; each toggle starts one frame, value = buffer half sent.
- sel  out  SELW  index of the granted source; drives the payload mux.
- gnt  out  NREQ  one-hot grant, held from the `idx` toggle until the frame ends.
- done  out  NREQ  1-cycle pulse to the granted source at frame end (success or error).
- err  out  1  1-cycle pulse on start timeout or length overrun.
- busy  out  1  high in any state other than IDLE.
- frames  out  16  count of successfully sent frames, wraps 0xFFFF->0.

Behaviour:
- All outputs are registered.
- Reset values: idx=0, sel=0, gnt=0, done=0, err=0, busy=1, frames=0, RR pointer=NREQ-1, state=DRAIN.
- States: DRAIN, GAP, IDLE, KICK, SEND.
- DRAIN (reset entry): wait for txctl=0, then GAP. Reset mid-frame may leave the transmitter running, and forcing idx=0 may itself retrigger it. DRAIN absorbs both cases; no grant is issued until the wire is idle.
- GAP: counter runs 0..IFG-1 while txctl=0 → IDLE. If txctl rises during GAP, the counter restarts.
- IDLE: if req≠0 at cycle N, then at N+1:
  - gnt = one-hot of the first set req bit searching ptr+1, ptr+2, … modulo NREQ;
  - sel = its index; ptr = that index;
  - idx toggles; state = KICK; KICK counter cleared.
- IDLE with req=0: outputs hold, busy=0.
- KICK:
  - txctl=1 → SEND, SEND counter cleared.
  - Otherwise, after TMO cycles in KICK: err=1 and done[sel]=1 for one cycle, gnt=0, state GAP. frames is unchanged.
- SEND:
  - txctl=0 → done[sel]=1, frames+1, gnt=0, state GAP.
  - SEND counter reaches MAXLEN with txctl still 1 → err=1, done[sel]=1, gnt=0, state DRAIN. frames is unchanged.
- sel is never changed outside the IDLE→KICK transition. sel keeps its last value after gnt clears.
- req deassertion while granted is ignored: the frame completes and done still pulses.
- A source holding req high is re-granted only after every other requesting source has had a turn.
- done and err are never high for more than 1 cycle. At most one done bit is high at a time.
- Counters are 11 bits, saturating. TMO and MAXLEN must each be < 2048.

Test Plan:
- Reset mid-frame: assert rst while txctl=1 for 300 more cycles → idx=0 and gnt=0 throughout; first toggle of idx occurs no earlier than IFG+1 cycles after txctl falls.
- Single source: req=4'b0100, transmitter model raises txctl 6 cycles after the toggle and holds it 1052 cycles → gnt=4'b0100, sel=2, idx 0→1, done=4'b0100 one cycle after txctl falls, frames=1, next grant ≥ IFG cycles later.
- Round robin: req=4'b1111 held for 8 frames → grant order 0,1,2,3,0,1,2,3; idx alternates 1,0,1,…; frames=8.
- Start timeout: model never raises txctl, req=4'b0001 → err and done[0] pulse exactly TMO cycles after entering KICK; frames unchanged; next grant after IFG cycles.
- Overrun: txctl held high 1200 cycles → err and done pulse at SEND count MAXLEN=1100; state DRAIN until txctl falls, then IFG gap.
- Requester drop: req[1] deasserted mid-SEND → frame finishes, done[1] pulses, source 1 not re-granted while req[1]=0.
